ines_loader: RTL and testbench

- Host-side ROM programmer that drives the cartridge programming interface: PRG/CHR ROM write strobes, shared address and data, and the header flags is_chr_ram and mirroring_mode.
- Consumes a raw iNES file as a valid/ready byte stream, e.g. from a UART or SD bridge.
- Parses and validates the 16-byte header, skips the optional trainer, then streams PRG and CHR payload bytes into the ROM memories.
- Holds busy high for the duration of the load so the system stays in reset until loading completes.

---
 rtl/ines_loader_if.sv | 22 ++
 rtl/ines_loader.sv | 223 ++++++++++++++++++++++
 tb/tb_ines_loader.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ines_loader_if.sv
// Byte-stream input and ROM programming bus of the iNES loader.
// Pure wiring: no storage, no latency.
// Backpressure: in_ready is owned by the loader (slave) side.
interface ines_loader_if;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] rom_prgmr_addr;
  logic [7:0]  rom_prgmr_data;
  logic        prg_rom_prgmr_wren;
  logic        chr_rom_prgmr_wren;

  modport slave (
    input  in_data, in_valid,
    output in_ready, rom_prgmr_addr, rom_prgmr_data, prg_rom_prgmr_wren, chr_rom_prgmr_wren
  );

  modport master (
    output in_data, in_valid,
    input  in_ready, rom_prgmr_addr, rom_prgmr_data, prg_rom_prgmr_wren, chr_rom_prgmr_wren
  );
endinterface

// File: rtl/ines_loader.sv
// Parses an iNES byte stream and programs PRG/CHR ROM images through the cartridge programmer bus.
// Latency: each accepted payload byte is written exactly one cycle after acceptance.
// Backpressure: in_ready is a pure state decode; the loader stalls cleanly on in_valid gaps.
module ines_loader #(
  parameter int unsigned PRG_MAX_BANKS = 2,
  parameter int unsigned CHR_MAX_BANKS = 1
) (
  input  logic         CLK,
  input  logic         RESET_n,
  input  logic         start,
  ines_loader_if.slave bus,
  output logic         is_chr_ram,
  output logic         mirroring_mode,
  output logic         busy,
  output logic         done,
  output logic         error,
  output logic [1:0]   err_code
);

  typedef enum logic [2:0] {
    S_IDLE, S_HEADER, S_TRAINER, S_PRG, S_CHR, S_DONE, S_ERROR
  } state_e;

  localparam logic [7:0] PRG_MAX = 8'(PRG_MAX_BANKS);
  localparam logic [7:0] CHR_MAX = 8'(CHR_MAX_BANKS);

  state_e      state_q, state_d;
  logic [4:0]  hdr_cnt_q, hdr_cnt_d;
  logic [16:0] cnt_q, cnt_d;
  logic [7:0]  prg_banks_q, prg_banks_d;
  logic [7:0]  chr_banks_q, chr_banks_d;
  logic [3:0]  mapper_lo_q, mapper_lo_d;
  logic [3:0]  mapper_hi_q, mapper_hi_d;
  logic        trainer_q, trainer_d;
  logic        mirror_hdr_q, mirror_hdr_d;
  logic        is_chr_ram_q, is_chr_ram_d;
  logic        mirroring_q, mirroring_d;
  logic [1:0]  err_code_q, err_code_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  data_q, data_d;
  logic        prg_wren_q, prg_wren_d;
  logic        chr_wren_q, chr_wren_d;

  logic        in_rdy;
  logic        accept;
  logic [7:0]  magic;
  logic [16:0] prg_len;
  logic [16:0] chr_len;

  // Ready depends only on the registered state, never on in_valid.
  assign in_rdy  = (state_q == S_HEADER) || (state_q == S_TRAINER) ||
                   (state_q == S_PRG)    || (state_q == S_CHR);
  assign accept  = bus.in_valid && in_rdy;
  // Bank counts are range-checked before use, so these slices cover every legal size.
  assign prg_len = {prg_banks_q[2:0], 14'd0};
  assign chr_len = {chr_banks_q[3:0], 13'd0};

  // Expected "NES<EOF>" signature byte for header positions 0-3.
  always_comb begin
    magic = 8'h1A;
    case (hdr_cnt_q[1:0])
      2'd0:    magic = 8'h4E;
      2'd1:    magic = 8'h45;
      2'd2:    magic = 8'h53;
      default: magic = 8'h1A;
    endcase
  end

  // Next-state, header capture, segment counting and write-strobe generation.
  always_comb begin
    state_d      = state_q;
    hdr_cnt_d    = hdr_cnt_q;
    cnt_d        = cnt_q;
    prg_banks_d  = prg_banks_q;
    chr_banks_d  = chr_banks_q;
    mapper_lo_d  = mapper_lo_q;
    mapper_hi_d  = mapper_hi_q;
    trainer_d    = trainer_q;
    mirror_hdr_d = mirror_hdr_q;
    is_chr_ram_d = is_chr_ram_q;
    mirroring_d  = mirroring_q;
    err_code_d   = err_code_q;
    addr_d       = addr_q;
    data_d       = data_q;
    prg_wren_d   = 1'b0;
    chr_wren_d   = 1'b0;

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_d      = S_HEADER;
          hdr_cnt_d    = 5'd0;
          cnt_d        = 17'd0;
          err_code_d   = 2'd0;
          is_chr_ram_d = 1'b0;
          mirroring_d  = 1'b0;
        end
      end
      S_HEADER: begin
        if (accept) begin
          hdr_cnt_d = hdr_cnt_q + 5'd1;
          if ((hdr_cnt_q < 5'd4) && (bus.in_data != magic)) begin
            state_d    = S_ERROR;
            err_code_d = 2'd1;
          end
          case (hdr_cnt_q)
            5'd4: prg_banks_d = bus.in_data;
            5'd5: chr_banks_d = bus.in_data;
            5'd6: begin
              mapper_lo_d  = bus.in_data[7:4];
              trainer_d    = bus.in_data[2];
              mirror_hdr_d = bus.in_data[0];
            end
            5'd7: mapper_hi_d = bus.in_data[7:4];
            5'd15: begin
              // Mapper support outranks size limits when both are violated.
              if ((mapper_lo_q | mapper_hi_q) != 4'd0) begin
                state_d    = S_ERROR;
                err_code_d = 2'd3;
              end else if ((prg_banks_q == 8'd0) || (prg_banks_q > PRG_MAX) ||
                           (chr_banks_q > CHR_MAX)) begin
                state_d    = S_ERROR;
                err_code_d = 2'd2;
              end else begin
                mirroring_d  = mirror_hdr_q;
                is_chr_ram_d = (chr_banks_q == 8'd0);
                cnt_d        = 17'd0;
                state_d      = trainer_q ? S_TRAINER : S_PRG;
              end
            end
            default: ;
          endcase
        end
      end
      S_TRAINER: begin
        if (accept) begin
          cnt_d = cnt_q + 17'd1;
          if (cnt_q == 17'd511) begin
            cnt_d   = 17'd0;
            state_d = S_PRG;
          end
        end
      end
      S_PRG: begin
        if (accept) begin
          prg_wren_d = 1'b1;
          addr_d     = cnt_q[15:0];
          data_d     = bus.in_data;
          cnt_d      = cnt_q + 17'd1;
          if (cnt_q == prg_len - 17'd1) begin
            cnt_d   = 17'd0;
            state_d = (chr_banks_q == 8'd0) ? S_DONE : S_CHR;
          end
        end
      end
      S_CHR: begin
        if (accept) begin
          chr_wren_d = 1'b1;
          addr_d     = cnt_q[15:0];
          data_d     = bus.in_data;
          cnt_d      = cnt_q + 17'd1;
          if (cnt_q == chr_len - 17'd1) begin
            cnt_d   = 17'd0;
            state_d = S_DONE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset drops any pending strobe immediately.
  always_ff @(posedge CLK) begin
    if (!RESET_n) begin
      state_q      <= S_IDLE;
      hdr_cnt_q    <= 5'd0;
      cnt_q        <= 17'd0;
      prg_banks_q  <= 8'd0;
      chr_banks_q  <= 8'd0;
      mapper_lo_q  <= 4'd0;
      mapper_hi_q  <= 4'd0;
      trainer_q    <= 1'b0;
      mirror_hdr_q <= 1'b0;
      is_chr_ram_q <= 1'b0;
      mirroring_q  <= 1'b0;
      err_code_q   <= 2'd0;
      addr_q       <= 16'd0;
      data_q       <= 8'd0;
      prg_wren_q   <= 1'b0;
      chr_wren_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      hdr_cnt_q    <= hdr_cnt_d;
      cnt_q        <= cnt_d;
      prg_banks_q  <= prg_banks_d;
      chr_banks_q  <= chr_banks_d;
      mapper_lo_q  <= mapper_lo_d;
      mapper_hi_q  <= mapper_hi_d;
      trainer_q    <= trainer_d;
      mirror_hdr_q <= mirror_hdr_d;
      is_chr_ram_q <= is_chr_ram_d;
      mirroring_q  <= mirroring_d;
      err_code_q   <= err_code_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      prg_wren_q   <= prg_wren_d;
      chr_wren_q   <= chr_wren_d;
    end
  end

  assign bus.in_ready           = in_rdy;
  assign bus.rom_prgmr_addr     = addr_q;
  assign bus.rom_prgmr_data     = data_q;
  assign bus.prg_rom_prgmr_wren = prg_wren_q;
  assign bus.chr_rom_prgmr_wren = chr_wren_q;
  assign is_chr_ram             = is_chr_ram_q;
  assign mirroring_mode         = mirroring_q;
  assign busy                   = in_rdy;
  assign done                   = (state_q == S_DONE);
  assign error                  = (state_q == S_ERROR);
  assign err_code               = err_code_q;

endmodule

// File: tb/tb_ines_loader.sv
// Self-checking bench for ines_loader: random iNES files against a file-level model.
// Latency: payload writes expected one cycle after acceptance.
// Backpressure: driver holds in_valid until in_ready, with optional random gaps.
module tb_ines_loader;
  localparam int TB_PRG_MAX = 2;
  localparam int TB_CHR_MAX = 1;

  logic       CLK = 1'b0;
  logic       RESET_n = 1'b0;
  logic       start = 1'b0;
  logic       is_chr_ram, mirroring_mode, busy, done, error;
  logic [1:0] err_code;

  ines_loader_if bus ();

  ines_loader #(.PRG_MAX_BANKS(TB_PRG_MAX), .CHR_MAX_BANKS(TB_CHR_MAX)) dut (
    .CLK(CLK), .RESET_n(RESET_n), .start(start), .bus(bus),
    .is_chr_ram(is_chr_ram), .mirroring_mode(mirroring_mode), .busy(busy),
    .done(done), .error(error), .err_code(err_code)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  logic [7:0]  file[$];
  logic [23:0] prg_log[$];
  logic [23:0] chr_log[$];

  // Monitor state (written only by the monitor process).
  int          lat_err = 0, hold_err = 0, dual_err = 0, done_rise_cnt = 0;
  logic        prev_acc = 1'b0, done_prev = 1'b0, prev_rst = 1'b0;
  logic [7:0]  prev_byte = 8'h00, last_data = 8'h00;
  logic [15:0] last_addr = 16'h0000;

  // Model outputs.
  int         m_acc, m_prg_off, m_prg_n, m_chr_off, m_chr_n;
  logic [1:0] m_ec;
  logic       m_ok, m_chr_ram, m_mir;

  // Snapshots of the logs/counters at the start of a scenario.
  int pb, cb, lb, hb, db, drb;

  always @(negedge CLK) begin
    if (bus.prg_rom_prgmr_wren) prg_log.push_back({bus.rom_prgmr_addr, bus.rom_prgmr_data});
    if (bus.chr_rom_prgmr_wren) chr_log.push_back({bus.rom_prgmr_addr, bus.rom_prgmr_data});
    if (bus.prg_rom_prgmr_wren && bus.chr_rom_prgmr_wren) dual_err++;
    if (bus.prg_rom_prgmr_wren || bus.chr_rom_prgmr_wren) begin
      if (!prev_acc || (bus.rom_prgmr_data != prev_byte)) lat_err++;
    end else if (prev_rst && ((bus.rom_prgmr_addr != last_addr) || (bus.rom_prgmr_data != last_data))) begin
      hold_err++;
    end
    if (done && !done_prev && (bus.prg_rom_prgmr_wren || bus.chr_rom_prgmr_wren)) done_rise_cnt++;
    last_addr = bus.rom_prgmr_addr;
    last_data = bus.rom_prgmr_data;
    prev_acc  = bus.in_valid & bus.in_ready;
    prev_byte = bus.in_data;
    done_prev = done;
    prev_rst  = RESET_n;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got time limit reached, want summary before limit");
    $fatal(1, "watchdog");
  end

  task automatic build_file(input logic [7:0] m2, input logic [7:0] b4, input logic [7:0] b5,
                            input logic [7:0] b6, input logic [7:0] b7);
    int n;
    file.delete();
    file.push_back(8'h4E); file.push_back(8'h45); file.push_back(m2); file.push_back(8'h1A);
    file.push_back(b4); file.push_back(b5); file.push_back(b6); file.push_back(b7);
    repeat (8) file.push_back(8'h00);
    if (b6[2]) repeat (512) file.push_back(8'hEE);
    n = ((b4 > 8'd4) ? 0 : int'(b4)) * 16384 + ((b5 > 8'd8) ? 0 : int'(b5)) * 8192 + 8;
    repeat (n) file.push_back(8'($urandom));
  endtask

  // File-level reference: what the loader should accept, write and report.
  task automatic run_model();
    logic [7:0] sig [4];
    sig = '{8'h4E, 8'h45, 8'h53, 8'h1A};
    m_ok = 0; m_ec = 0; m_chr_ram = 0; m_mir = 0;
    m_prg_off = 0; m_prg_n = 0; m_chr_off = 0; m_chr_n = 0;
    for (int i = 0; i < 4; i++) begin
      if (file[i] != sig[i]) begin m_acc = i + 1; m_ec = 2'd1; return; end
    end
    m_acc = 16;
    if ((file[6][7:4] | file[7][7:4]) != 4'd0) begin m_ec = 2'd3; return; end
    if ((file[4] == 0) || (int'(file[4]) > TB_PRG_MAX) || (int'(file[5]) > TB_CHR_MAX)) begin
      m_ec = 2'd2; return;
    end
    m_ok      = 1;
    m_chr_ram = (file[5] == 0);
    m_mir     = file[6][0];
    m_prg_off = 16 + (file[6][2] ? 512 : 0);
    m_prg_n   = int'(file[4]) * 16384;
    m_chr_off = m_prg_off + m_prg_n;
    m_chr_n   = int'(file[5]) * 8192;
    m_acc     = m_chr_off + m_chr_n;
  endtask

  task automatic snap();
    pb = prg_log.size(); cb = chr_log.size(); lb = lat_err; hb = hold_err; db = dual_err; drb = done_rise_cnt;
  endtask

  // First index where logged writes differ from {offset, file byte}; -1 if all n match.
  function automatic int first_bad(input bit is_chr, input int base, input int off, input int n);
    logic [23:0] got, want;
    for (int k = 0; k < n; k++) begin
      if (is_chr) begin
        if (base + k >= chr_log.size()) return k;
        got = chr_log[base + k];
      end else begin
        if (base + k >= prg_log.size()) return k;
        got = prg_log[base + k];
      end
      want = {16'(k), file[off + k]};
      if (got !== want) return k;
    end
    return -1;
  endfunction

  task automatic send(input logic [7:0] b, input int gap_pct, output bit ok);
    int waitc = 0;
    while ((gap_pct > 0) && ($urandom_range(0, 99) < gap_pct)) begin
      bus.in_valid = 1'b0;
      @(posedge CLK); #1;
    end
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    ok = 1'b0;
    while (waitc < 8) begin
      @(negedge CLK);
      if (bus.in_ready) begin
        @(posedge CLK); #1;
        ok = 1'b1;
        break;
      end
      @(posedge CLK); #1;
      waitc++;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic run_load(input int max_n, input int gap_pct, input int start_at,
                          output int acc, output logic busy_at_start);
    bit ok;
    acc = 0;
    @(posedge CLK); #1; start = 1'b1;
    @(posedge CLK); #1; start = 1'b0;
    busy_at_start = busy;
    for (int i = 0; (i < file.size()) && (i < max_n); i++) begin
      if (i == start_at) start = 1'b1;
      send(file[i], gap_pct, ok);
      start = 1'b0;
      if (!ok) break;
      acc++;
    end
  endtask

  task automatic test_reset();
    RESET_n = 1'b0; bus.in_valid = 1'b0; bus.in_data = 8'h00;
    repeat (3) @(posedge CLK);
    #1; RESET_n = 1'b1;
    checks++;
    if ({busy, done, error, err_code, is_chr_ram, mirroring_mode, bus.in_ready} !== 8'd0) begin
      errors++;
      $display("FAIL reset_status: got %b want 0", {busy, done, error, err_code, is_chr_ram, mirroring_mode, bus.in_ready});
    end
    checks++;
    if ({bus.rom_prgmr_addr, bus.rom_prgmr_data, bus.prg_rom_prgmr_wren, bus.chr_rom_prgmr_wren} !== 26'd0) begin
      errors++;
      $display("FAIL reset_bus: got addr=%h data=%h wren=%b%b want all 0", bus.rom_prgmr_addr,
               bus.rom_prgmr_data, bus.prg_rom_prgmr_wren, bus.chr_rom_prgmr_wren);
    end
  endtask

  task automatic test_basic();
    int acc; logic bs; int fb;
    build_file(8'h53, 8'd1, 8'd1, 8'h00, 8'h00);
    run_model(); snap();
    run_load(file.size(), 0, -1, acc, bs);
    repeat (2) @(posedge CLK); #1;
    checks++; if (bs !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b want 1", bs); end
    checks++; if (acc !== m_acc) begin errors++; $display("FAIL basic_accepted: got %0d want %0d", acc, m_acc); end
    checks++; if (prg_log.size() - pb !== m_prg_n) begin errors++; $display("FAIL basic_prg_count: got %0d want %0d", prg_log.size() - pb, m_prg_n); end
    fb = first_bad(1'b0, pb, m_prg_off, m_prg_n);
    checks++; if (fb !== -1) begin errors++; $display("FAIL basic_prg_stream: got mismatch at %0d want none", fb); end
    checks++; if (chr_log.size() - cb !== m_chr_n) begin errors++; $display("FAIL basic_chr_count: got %0d want %0d", chr_log.size() - cb, m_chr_n); end
    fb = first_bad(1'b1, cb, m_chr_off, m_chr_n);
    checks++; if (fb !== -1) begin errors++; $display("FAIL basic_chr_stream: got mismatch at %0d want none", fb); end
    checks++; if ({done, error, busy} !== 3'b100) begin errors++; $display("FAIL basic_done: got done/err/busy=%b want 100", {done, error, busy}); end
    checks++; if ({is_chr_ram, mirroring_mode} !== {m_chr_ram, m_mir}) begin errors++; $display("FAIL basic_flags: got %b want %b", {is_chr_ram, mirroring_mode}, {m_chr_ram, m_mir}); end
    checks++; if (done_rise_cnt - drb !== 1) begin errors++; $display("FAIL basic_done_with_strobe: got %0d want 1", done_rise_cnt - drb); end
    checks++; if ({lat_err - lb, hold_err - hb, dual_err - db} !== 96'd0) begin errors++; $display("FAIL basic_timing: got lat=%0d hold=%0d dual=%0d want 0", lat_err - lb, hold_err - hb, dual_err - db); end
  endtask

  task automatic test_bad_magic();
    int acc; logic bs;
    build_file(8'h54, 8'd1, 8'd0, 8'h00, 8'h00);
    run_model(); snap();
    run_load(file.size(), 0, -1, acc, bs);
    checks++; if (acc !== m_acc) begin errors++; $display("FAIL magic_accepted: got %0d want %0d", acc, m_acc); end
    checks++; if ({error, done, err_code} !== {2'b10, m_ec}) begin errors++; $display("FAIL magic_status: got err/done/code=%b want %b", {error, done, err_code}, {2'b10, m_ec}); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL magic_ready: got %b want 0", bus.in_ready); end
    checks++; if ((prg_log.size() - pb) + (chr_log.size() - cb) !== 0) begin errors++; $display("FAIL magic_strobes: got %0d want 0", (prg_log.size() - pb) + (chr_log.size() - cb)); end
  endtask

  // Starts from the ERROR state left by the previous scenario.
  task automatic test_trainer();
    int acc; logic bs; int fb;
    build_file(8'h53, 8'd1, 8'd0, 8'h04, 8'h00);
    run_model(); snap();
    run_load(file.size(), 0, -1, acc, bs);
    repeat (2) @(posedge CLK); #1;
    checks++; if (acc !== m_acc) begin errors++; $display("FAIL trainer_accepted: got %0d want %0d", acc, m_acc); end
    checks++; if (prg_log.size() - pb !== m_prg_n) begin errors++; $display("FAIL trainer_prg_count: got %0d want %0d", prg_log.size() - pb, m_prg_n); end
    checks++;
    if ((prg_log.size() <= pb) || (prg_log[pb] !== {16'h0000, file[528]})) begin
      errors++; $display("FAIL trainer_first_write: got %h want %h", (prg_log.size() > pb) ? prg_log[pb] : 24'hxxxxxx, {16'h0000, file[528]});
    end
    fb = first_bad(1'b0, pb, m_prg_off, m_prg_n);
    checks++; if (fb !== -1) begin errors++; $display("FAIL trainer_prg_stream: got mismatch at %0d want none", fb); end
    checks++; if (chr_log.size() - cb !== 0) begin errors++; $display("FAIL trainer_chr_count: got %0d want 0", chr_log.size() - cb); end
    checks++; if ({done, error, err_code, is_chr_ram} !== 5'b10001) begin errors++; $display("FAIL trainer_status: got %b want 10001", {done, error, err_code, is_chr_ram}); end
    checks++; if (lat_err - lb !== 0) begin errors++; $display("FAIL trainer_latency: got %0d want 0", lat_err - lb); end
  endtask

  task automatic test_header_errors();
    logic [7:0] tbl [6][4];
    int acc; logic bs;
    tbl = '{'{8'd3, 8'd1, 8'h00, 8'h00}, '{8'd1, 8'd1, 8'h10, 8'h00}, '{8'd0, 8'd1, 8'h00, 8'h00},
            '{8'd1, 8'd2, 8'h00, 8'h00}, '{8'd1, 8'd1, 8'h00, 8'h20}, '{8'd3, 8'd1, 8'h11, 8'h00}};
    for (int t = 0; t < 6; t++) begin
      build_file(8'h53, tbl[t][0], tbl[t][1], tbl[t][2], tbl[t][3]);
      run_model(); snap();
      run_load(file.size(), 0, -1, acc, bs);
      checks++; if (acc !== m_acc) begin errors++; $display("FAIL hdr_err%0d_accepted: got %0d want %0d", t, acc, m_acc); end
      checks++; if ({error, done, err_code} !== {2'b10, m_ec}) begin errors++; $display("FAIL hdr_err%0d_status: got %b want %b", t, {error, done, err_code}, {2'b10, m_ec}); end
      checks++; if ((prg_log.size() - pb) + (chr_log.size() - cb) !== 0) begin errors++; $display("FAIL hdr_err%0d_strobes: got %0d want 0", t, (prg_log.size() - pb) + (chr_log.size() - cb)); end
    end
  endtask

  task automatic test_reset_mid_load();
    int acc; logic bs; int fb;
    build_file(8'h53, 8'd2, 8'd0, 8'h01, 8'h00);
    run_model(); snap();
    run_load(5000, 20, 3000, acc, bs);
    RESET_n = 1'b0;
    @(posedge CLK); #1;
    RESET_n = 1'b1;
    checks++; if (acc !== 5000) begin errors++; $display("FAIL midrst_accepted: got %0d want 5000", acc); end
    checks++; if (prg_log.size() - pb !== 5000 - m_prg_off) begin errors++; $display("FAIL midrst_prg_count: got %0d want %0d", prg_log.size() - pb, 5000 - m_prg_off); end
    fb = first_bad(1'b0, pb, m_prg_off, 5000 - m_prg_off);
    checks++; if (fb !== -1) begin errors++; $display("FAIL midrst_contiguous: got mismatch at %0d want none", fb); end
    checks++; if ({lat_err - lb, hold_err - hb} !== 64'd0) begin errors++; $display("FAIL midrst_timing: got lat=%0d hold=%0d want 0", lat_err - lb, hold_err - hb); end
    checks++;
    if ({busy, done, error, err_code, is_chr_ram, mirroring_mode, bus.in_ready, bus.rom_prgmr_addr,
         bus.rom_prgmr_data, bus.prg_rom_prgmr_wren, bus.chr_rom_prgmr_wren} !== 34'd0) begin
      errors++; $display("FAIL midrst_outputs: got busy=%b addr=%h data=%h flags=%b want all 0", busy,
                         bus.rom_prgmr_addr, bus.rom_prgmr_data, {is_chr_ram, mirroring_mode});
    end
    snap();
    repeat (20) @(posedge CLK);
    #1;
    checks++; if ((prg_log.size() - pb) + (chr_log.size() - cb) !== 0) begin errors++; $display("FAIL midrst_no_strobes: got %0d want 0", (prg_log.size() - pb) + (chr_log.size() - cb)); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_idle: got busy=%b want 0", busy); end
  endtask

  // Full reload after the mid-load reset: two PRG banks, CHR RAM, vertical mirroring.
  task automatic test_chr_ram_2bank();
    int acc; logic bs; int fb;
    build_file(8'h53, 8'd2, 8'd0, 8'h01, 8'h00);
    run_model(); snap();
    run_load(file.size(), 0, -1, acc, bs);
    repeat (2) @(posedge CLK); #1;
    checks++; if (acc !== m_acc) begin errors++; $display("FAIL chrram_accepted: got %0d want %0d", acc, m_acc); end
    checks++; if (prg_log.size() - pb !== m_prg_n) begin errors++; $display("FAIL chrram_prg_count: got %0d want %0d", prg_log.size() - pb, m_prg_n); end
    fb = first_bad(1'b0, pb, m_prg_off, m_prg_n);
    checks++; if (fb !== -1) begin errors++; $display("FAIL chrram_prg_stream: got mismatch at %0d want none", fb); end
    checks++; if (chr_log.size() - cb !== 0) begin errors++; $display("FAIL chrram_chr_count: got %0d want 0", chr_log.size() - cb); end
    checks++; if ({is_chr_ram, mirroring_mode} !== {m_chr_ram, m_mir}) begin errors++; $display("FAIL chrram_flags: got %b want %b", {is_chr_ram, mirroring_mode}, {m_chr_ram, m_mir}); end
    checks++; if ({done, error} !== 2'b10) begin errors++; $display("FAIL chrram_done: got %b want 10", {done, error}); end
    checks++; if (done_rise_cnt - drb !== 1) begin errors++; $display("FAIL chrram_done_with_strobe: got %0d want 1", done_rise_cnt - drb); end
    checks++; if ({lat_err - lb, dual_err - db} !== 64'd0) begin errors++; $display("FAIL chrram_timing: got lat=%0d dual=%0d want 0", lat_err - lb, dual_err - db); end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    test_reset();
    test_basic();
    test_bad_magic();
    test_trainer();
    test_header_errors();
    test_reset_mid_load();
    test_chr_ram_2bank();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
